// File: rtl/switch_input_ctrl.sv
// rtl/switch_input_ctrl.sv - debounced switch input peripheral with pending/mask regs; SWITCH_INPUT_IRQ_EN adds irq and IRQ_CTRL at +12
module switch_input_ctrl #(
   parameter int          WIDTH     = 24,
   parameter logic [31:0] BASE_ADDR = 32'hfffffc70,
   parameter int          TICK_DIV  = 1000,
   parameter int          DEB_TICKS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic             en,
   input  logic [3:0]       byte_sel,
   input  logic [31:0]      data_in,
   input  logic             we,
   output logic [31:0]      data_out,
   input  logic [WIDTH-1:0] switch_in,
   output logic             irq
);

   localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [7:0]       DEB_LAST = 8'(DEB_TICKS - 1);

   logic [WIDTH-1:0] sync1, sync2, stable, stable_nxt, chg;
   logic [WIDTH-1:0] pending, mask, wr_lane, pend_clr;
   logic [7:0]       cnt     [WIDTH];
   logic [7:0]       cnt_nxt [WIDTH];
   logic [DIV_W-1:0] div;
   logic             tick;
   logic             sel_state, sel_pend, sel_mask, sel_ictl;
   logic             unused_bits;

   assign sel_state = en && (addr == BASE_ADDR);
   assign sel_pend  = en && (addr == BASE_ADDR + 32'd4);
   assign sel_mask  = en && (addr == BASE_ADDR + 32'd8);
   assign sel_ictl  = en && (addr == BASE_ADDR + 32'd12);
   assign tick      = (div == DIV_LAST);
   assign chg       = stable_nxt ^ stable;
   assign unused_bits = ^{data_in, byte_sel, sel_ictl};

   always_comb begin
      wr_lane = '0;
      for (int i = 0; i < WIDTH; i++)
         wr_lane[i] = byte_sel[i / 8];
   end

   assign pend_clr = (we && sel_pend) ? (data_in[WIDTH-1:0] & wr_lane) : '0;

   // A matching sample clears the count at once; only ticks advance it.
   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (sync2[i] == stable[i]) begin
            cnt_nxt[i] = 8'd0;
         end else if (tick) begin
            if (cnt[i] == DEB_LAST) begin
               stable_nxt[i] = sync2[i];
               cnt_nxt[i]    = 8'd0;
            end else begin
               cnt_nxt[i] = cnt[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         stable  <= '0;
         div     <= '0;
         pending <= '0;
         mask    <= '0;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= 8'd0;
      end else begin
         sync1  <= switch_in;
         sync2  <= sync1;
         stable <= stable_nxt;
         div    <= tick ? '0 : div + 1'b1;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= cnt_nxt[i];
         // A new change outranks a simultaneous W1C on the same bit.
         pending <= (pending & ~pend_clr) | (chg & mask);
         if (we && sel_mask)
            mask <= (mask & ~wr_lane) | (data_in[WIDTH-1:0] & wr_lane);
      end
   end

`ifdef SWITCH_INPUT_IRQ_EN
   logic irq_en, irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         if (we && sel_ictl && byte_sel[0])
            irq_en <= data_in[0];
         irq_q <= (|pending) & irq_en;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      data_out = 32'h0;
      if (!rst && !we) begin
         if (sel_state) data_out[WIDTH-1:0] = stable;
         if (sel_pend)  data_out[WIDTH-1:0] = pending;
         if (sel_mask)  data_out[WIDTH-1:0] = mask;
`ifdef SWITCH_INPUT_IRQ_EN
         if (sel_ictl)  data_out[0] = irq_en;
`endif
      end
   end

endmodule
